// File: rtl/video_relay.sv
// video_relay: registered HDMI video path with per-frame pixel mode,
// resolution/frame measurement and a frame-locked heartbeat.
module video_relay #(
    parameter int          DATA_W    = 24,
    parameter int          LATENCY   = 2,
    parameter int          SYNC_POL  = 1,
    parameter int          FRAME_W   = 16,
    parameter int          DIM_W     = 12,
    parameter int          HB_FRAMES = 30,
    parameter logic [23:0] SOLID_RGB = 24'h000080
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [1:0]         mode_i,
    input  logic               vin_de_i,
    input  logic               vin_hs_i,
    input  logic               vin_vs_i,
    input  logic [DATA_W-1:0]  vin_data_i,
    output logic               vout_de_o,
    output logic               vout_hs_o,
    output logic               vout_vs_o,
    output logic [DATA_W-1:0]  vout_data_o,
    output logic [1:0]         mode_o,
    output logic [FRAME_W-1:0] frame_cnt_o,
    output logic [DIM_W-1:0]   width_o,
    output logic [DIM_W-1:0]   height_o,
    output logic               heartbeat_o
);
    localparam int                 HB_W     = $clog2(HB_FRAMES + 1);
    localparam int                 PW       = DATA_W + 3;
    localparam logic [DATA_W-1:0]  SOLID    = DATA_W'(SOLID_RGB);
    localparam logic [DIM_W-1:0]   DIM_ONE  = DIM_W'(1);
    localparam logic [FRAME_W-1:0] FRM_ONE  = FRAME_W'(1);
    localparam logic [HB_W-1:0]    HB_ONE   = HB_W'(1);
    localparam logic [HB_W-1:0]    HB_LAST  = HB_W'(HB_FRAMES - 1);
    localparam logic               VS_ACT   = 1'(SYNC_POL);

    logic               vs_act, fe, le, hb_wrap;
    logic               armed_q, vs_prev_q, de_prev_q, heart_q;
    logic [1:0]         mode_q, mode_eff;
    logic [DATA_W-1:0]  px_d;
    logic [PW-1:0]      pipe_q [LATENCY];
    logic [DIM_W-1:0]   pix_q, pix_d, len_q, len_d, lines_q, lines_inc, lines_d;
    logic [DIM_W-1:0]   width_q, height_q;
    logic [FRAME_W-1:0] frame_q;
    logic [HB_W-1:0]    hb_q, hb_d;

    always_comb begin
        vs_act    = vin_vs_i == VS_ACT;
        // armed_q keeps the very first sample after reset from forming a frame edge
        fe        = vs_act & ~vs_prev_q & armed_q;
        le        = de_prev_q & ~vin_de_i;
        mode_eff  = fe ? mode_i : mode_q;
        px_d      = !vin_de_i ? '0 :
                    mode_eff == 2'd0 ? vin_data_i :
                    mode_eff == 2'd1 ? ~vin_data_i :
                    mode_eff == 2'd2 ? '0 : SOLID;
        pix_d     = (fe || !vin_de_i) ? '0 : (&pix_q) ? pix_q : pix_q + DIM_ONE;
        len_d     = le ? pix_q : len_q;
        lines_inc = (le && !(&lines_q)) ? lines_q + DIM_ONE : lines_q;
        lines_d   = fe ? '0 : lines_inc;
        hb_wrap   = hb_q == HB_LAST;
        hb_d      = hb_wrap ? '0 : hb_q + HB_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed_q   <= 1'b0;
            vs_prev_q <= 1'b0;
            de_prev_q <= 1'b0;
            pix_q     <= '0;
            len_q     <= '0;
            lines_q   <= '0;
            mode_q    <= '0;
            width_q   <= '0;
            height_q  <= '0;
            frame_q   <= '0;
            hb_q      <= '0;
            heart_q   <= 1'b0;
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            armed_q   <= 1'b1;
            vs_prev_q <= vs_act;
            de_prev_q <= vin_de_i;
            pix_q     <= pix_d;
            len_q     <= len_d;
            lines_q   <= lines_d;
            pipe_q[0] <= {vin_de_i, vin_hs_i, vin_vs_i, px_d};
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            // a line ending on the frame edge still belongs to the ending frame
            if (fe) begin
                mode_q   <= mode_i;
                width_q  <= len_d;
                height_q <= lines_inc;
                frame_q  <= frame_q + FRM_ONE;
                hb_q     <= hb_d;
                heart_q  <= heart_q ^ hb_wrap;
            end
        end
    end

    assign {vout_de_o, vout_hs_o, vout_vs_o, vout_data_o} = pipe_q[LATENCY-1];
    assign mode_o      = mode_q;
    assign frame_cnt_o = frame_q;
    assign width_o     = width_q;
    assign height_o    = height_q;
    assign heartbeat_o = heart_q;
endmodule

// File: tb/tb_video_relay.sv
// tb_video_relay: randomized frames against a behavioural model; a scoreboard
// queue carries expected video, status outputs are compared every cycle.
module tb_video_relay;
    localparam int          DW  = 24;
    localparam int          L   = 3;
    localparam int          SP  = 0;
    localparam int          FW  = 2;
    localparam int          DMW = 6;
    localparam int          HB  = 2;
    localparam logic [23:0] SOLID = 24'h000080;
    localparam logic        ACT = 1'(SP);
    localparam logic        INA = !ACT;

    typedef logic [DW+2:0] pix_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic          de, hs, vs;
    logic [DW-1:0] din;
    logic          vout_de, vout_hs, vout_vs, heartbeat;
    logic [DW-1:0] vout_data;
    logic [1:0]    mode_o;
    logic [FW-1:0] frame_cnt;
    logic [DMW-1:0] width, height;

    int vectors = 0;
    int miscompares = 0;

    pix_t exp_q[$];
    bit   m_vsprev, m_deprev, m_armed, m_hb;
    int   m_pix, m_lastlen, m_lines, m_fes, m_mode, m_width, m_height, m_frames;

    always #5 clk = ~clk;

    video_relay #(
        .DATA_W(DW), .LATENCY(L), .SYNC_POL(SP), .FRAME_W(FW),
        .DIM_W(DMW), .HB_FRAMES(HB), .SOLID_RGB(SOLID)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode),
        .vin_de_i(de), .vin_hs_i(hs), .vin_vs_i(vs), .vin_data_i(din),
        .vout_de_o(vout_de), .vout_hs_o(vout_hs), .vout_vs_o(vout_vs),
        .vout_data_o(vout_data), .mode_o(mode_o), .frame_cnt_o(frame_cnt),
        .width_o(width), .height_o(height), .heartbeat_o(heartbeat)
    );

    function automatic int sat(int v);
        return (v > (1 << DMW) - 1) ? (1 << DMW) - 1 : v;
    endfunction

    task automatic check(string n, logic [63:0] got, logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", n, got, want, $time);
        end
    endtask

    // reference model: frame/line bookkeeping in plain integers
    always @(posedge clk) begin
        bit vsa, fe, le;
        int me;
        logic [DW-1:0] d;
        if (!rst_n) begin
            exp_q.delete();
            m_vsprev = 0; m_deprev = 0; m_armed = 0; m_hb = 0;
            m_pix = 0; m_lastlen = 0; m_lines = 0; m_fes = 0;
            m_mode = 0; m_width = 0; m_height = 0; m_frames = 0;
        end else begin
            vsa = (vs == ACT);
            fe  = vsa && !m_vsprev && m_armed;
            le  = m_deprev && !de;
            me  = fe ? int'(mode) : m_mode;
            d   = !de ? '0 : me == 0 ? din : me == 1 ? ~din : me == 2 ? '0 : SOLID;
            exp_q.push_back({de, hs, vs, d});
            if (le) begin
                m_lastlen = m_pix;
                m_lines++;
            end
            if (fe) begin
                m_width  = sat(m_lastlen);
                m_height = sat(m_lines);
                m_lines  = 0;
                m_frames = (m_frames + 1) % (1 << FW);
                m_fes++;
                if (m_fes % HB == 0) m_hb = !m_hb;
                m_mode = mode;
            end
            m_pix = (fe || !de) ? 0 : m_pix + 1;
            m_vsprev = vsa;
            m_deprev = de;
            m_armed  = 1;
        end
    end

    always @(negedge clk) begin
        pix_t got, want;
        got = {vout_de, vout_hs, vout_vs, vout_data};
        want = (rst_n && exp_q.size() >= L) ? exp_q.pop_front() : '0;
        check("video", 64'(got), 64'(want));
        check("mode", 64'(mode_o), rst_n ? 64'(m_mode) : 64'd0);
        check("frame_cnt", 64'(frame_cnt), rst_n ? 64'(m_frames) : 64'd0);
        check("width", 64'(width), rst_n ? 64'(m_width) : 64'd0);
        check("height", 64'(height), rst_n ? 64'(m_height) : 64'd0);
        check("heartbeat", 64'(heartbeat), rst_n ? 64'(m_hb) : 64'd0);
    end

    task automatic cyc(logic d, logic h, logic v);
        de = d; hs = h; vs = v;
        din = DW'($urandom);
        mode = 2'($urandom);
        @(posedge clk);
        #2;
    endtask

    task automatic line(int w, int bl);
        for (int i = 0; i < w; i++) cyc(1'b1, INA, INA);
        for (int i = 0; i < bl; i++) cyc(1'b0, (i < 2) ? ACT : INA, INA);
    endtask

    task automatic vsync();
        for (int i = 0; i < 3; i++) cyc(1'b0, INA, ACT);
        for (int i = 0; i < 4; i++) cyc(1'b0, INA, INA);
    endtask

    task automatic frame(int w, int h, int tail);
        vsync();
        for (int l = 0; l < h - 1; l++) line(w, 2 + int'($urandom_range(0, 3)));
        line(w, tail);
    endtask

    initial begin
        rst_n = 1'b0; de = 1'b0; hs = INA; vs = INA; din = '0; mode = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) cyc(1'b0, INA, INA);
        frame(8, 5, 3);
        frame(12, 4, 0);
        frame(70, 3, 2);
        frame(2, 66, 2);
        for (int f = 0; f < 8; f++)
            frame(int'($urandom_range(1, 40)), int'($urandom_range(1, 20)), int'($urandom_range(0, 4)));
        vsync();
        line(10, 3);
        line(10, 3);
        repeat (4) cyc(1'b1, INA, INA);
        rst_n = 1'b0;
        repeat (3) cyc(1'b1, INA, INA);
        rst_n = 1'b1;
        repeat (6) cyc(1'b1, INA, INA);
        line(0, 3);
        line(10, 3);
        line(10, 3);
        frame(10, 6, 3);
        frame(14, 5, 3);
        vsync();
        repeat (L + 4) cyc(1'b0, INA, INA);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
